// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator with fetch-latency-matched pixel output stage
// Counters drive combinational fetch requests; sync/de/markers ride a FETCH_LAT delay line to meet returning pixel data.
module vga_timing_gen #(
  parameter int              H_ACTIVE    = 800,
  parameter int              H_FP        = 40,
  parameter int              H_SYNC      = 128,
  parameter int              H_BP        = 88,
  parameter int              V_ACTIVE    = 600,
  parameter int              V_FP        = 1,
  parameter int              V_SYNC      = 4,
  parameter int              V_BP        = 23,
  parameter logic            HS_POL      = 1'b1,
  parameter logic            VS_POL      = 1'b1,
  parameter int              COLOR_W     = 8,
  parameter logic [COLOR_W-1:0] BLANK_COLOR = 8'hF8,
  parameter int              FETCH_LAT   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          pattern,
  output logic                          pix_req,
  output logic [$clog2(H_ACTIVE)-1:0]   pix_x,
  output logic [$clog2(V_ACTIVE)-1:0]   pix_y,
  input  logic [COLOR_W-1:0]            pix_data,
  output logic                          hs,
  output logic                          vs,
  output logic                          de,
  output logic [COLOR_W-1:0]            color,
  output logic                          line_start,
  output logic                          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam int SW0     = ((XW > YW) ? XW : YW) + 1;
  localparam int SW      = (SW0 > 11) ? SW0 : 11;
  localparam int PW      = 6 + XW + YW;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0]      r_h;
  logic [VW-1:0]      r_v;
  logic               r_mode;
  logic               r_hs;
  logic               r_vs;
  logic               r_de;
  logic [COLOR_W-1:0] r_color;
  logic               r_ls;
  logic               r_fs;

  logic               w_h_act;
  logic               w_v_act;
  logic               w_hs_raw;
  logic               w_vs_raw;
  logic               w_line0;
  logic               w_origin;
  logic               w_mode;
  logic [PW-1:0]      w_head;
  logic [PW-1:0]      w_tail;
  logic               w_t_hs;
  logic               w_t_vs;
  logic               w_t_de;
  logic               w_t_ls;
  logic               w_t_fs;
  logic               w_t_mode;
  logic [XW-1:0]      w_t_x;
  logic [YW-1:0]      w_t_y;
  logic [COLOR_W-1:0] w_pat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (enable) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign w_h_act  = (r_h < H_ACT);
  assign w_v_act  = (r_v < V_ACT);
  assign pix_req  = w_h_act & w_v_act;
  assign pix_x    = pix_req ? r_h[XW-1:0] : '0;
  assign pix_y    = pix_req ? r_v[YW-1:0] : '0;
  assign w_hs_raw = (r_h >= HS_BEG) && (r_h < HS_END);
  assign w_vs_raw = (r_v >= VS_BEG) && (r_v < VS_END);
  assign w_line0  = (r_h == '0);
  assign w_origin = w_line0 && (r_v == '0);

  // Mode only changes at the frame origin, so the whole frame shares one source.
  assign w_mode = w_origin ? pattern : r_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= 1'b0;
    end else if (enable && w_origin) begin
      r_mode <= pattern;
    end
  end

  assign w_head = {w_hs_raw, w_vs_raw, pix_req, w_line0, w_origin, w_mode, pix_x, pix_y};

  generate
    if (FETCH_LAT == 0) begin : g_nodelay
      assign w_tail = w_head;
    end else begin : g_delay
      logic [PW-1:0] r_pipe [FETCH_LAT];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < FETCH_LAT; i++) r_pipe[i] <= '0;
        end else if (enable) begin
          r_pipe[0] <= w_head;
          for (int i = 1; i < FETCH_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign w_tail = r_pipe[FETCH_LAT-1];
    end
  endgenerate

  assign {w_t_hs, w_t_vs, w_t_de, w_t_ls, w_t_fs, w_t_mode, w_t_x, w_t_y} = w_tail;
  assign w_pat = COLOR_W'(SW'(w_t_x) + SW'(w_t_y));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
      r_de    <= 1'b0;
      r_color <= BLANK_COLOR;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
    end else if (enable) begin
      r_hs    <= HS_POL ? w_t_hs : ~w_t_hs;
      r_vs    <= VS_POL ? w_t_vs : ~w_t_vs;
      r_de    <= w_t_de;
      r_color <= w_t_de ? (w_t_mode ? w_pat : pix_data) : BLANK_COLOR;
      r_ls    <= w_t_ls;
      r_fs    <= w_t_fs;
    end
  end

  assign hs          = r_hs;
  assign vs          = r_vs;
  assign de          = r_de;
  assign color       = r_color;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed vector bench for vga_timing_gen
// DUT a: default timing, FETCH_LAT=2. DUT b: tiny 15x10 raster, FETCH_LAT=0, negative hsync.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       reset_a, enable_a, pattern_a;
  logic       req_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic [7:0] pd_a, color_a;

  vga_timing_gen u_dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .pattern(pattern_a),
    .pix_req(req_a), .pix_x(x_a), .pix_y(y_a), .pix_data(pd_a),
    .hs(hs_a), .vs(vs_a), .de(de_a), .color(color_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  logic       reset_b, enable_b, pattern_b;
  logic       req_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [2:0] x_b, y_b;
  logic [7:0] pd_b, color_b;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .COLOR_W(8), .BLANK_COLOR(8'hF8), .FETCH_LAT(0)
  ) u_dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .pattern(pattern_b),
    .pix_req(req_b), .pix_x(x_b), .pix_y(y_b), .pix_data(pd_b),
    .hs(hs_b), .vs(vs_b), .de(de_b), .color(color_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  int cyc_a = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc_a, act, exp);
    end
  endtask

  task automatic goto_a(input int c);
    while (cyc_a < c) begin
      @(negedge clk);
      cyc_a++;
    end
  endtask

  typedef struct {
    int         cyc;
    logic       req;
    int         x;
    int         y;
    logic       de;
    logic [7:0] color;
    logic       hs;
    logic       ls;
    logic       fs;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  // Small reference model for DUT b: 15 clocks per line, 10 lines per frame.
  bit pat_en = 1'b1;

  function automatic logic [7:0] pdv(input int c);
    return 8'((c * 7 + 3) & 255);
  endfunction

  function automatic logic pat_at(input int c);
    return pat_en && (c >= 40) && (c < 200);
  endfunction

  task automatic check_b(input int c);
    logic [19:0] exp_v, act_v;
    int h, v, p;
    logic req, de_e, mode, hs_e, vs_e, ls_e, fs_e;
    logic [2:0] xe, ye;
    logic [7:0] col;
    h = c % 15;
    v = (c / 15) % 10;
    req = (h < 8) && (v < 6);
    xe = req ? 3'(h) : 3'd0;
    ye = req ? 3'(v) : 3'd0;
    if (c == 0) begin
      de_e = 1'b0; col = 8'hF8; hs_e = 1'b1; vs_e = 1'b0; ls_e = 1'b0; fs_e = 1'b0;
    end else begin
      p = c - 1;
      h = p % 15;
      v = (p / 15) % 10;
      de_e = (h < 8) && (v < 6);
      mode = pat_at((p / 150) * 150);
      col  = de_e ? (mode ? 8'(h + v) : pdv(p)) : 8'hF8;
      hs_e = !((h >= 10) && (h < 13));
      vs_e = (v >= 7) && (v < 9);
      ls_e = (h == 0);
      fs_e = (h == 0) && (v == 0);
    end
    exp_v = {req, xe, ye, de_e, col, hs_e, vs_e, ls_e, fs_e};
    act_v = {req_b, x_b, y_b, de_b, color_b, hs_b, vs_b, ls_b, fs_b};
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL b_model cyc=%0d actual=%05h required=%05h", c, act_v, exp_v);
    end
  endtask

  initial begin
    vt[0]  = '{0,    1'b1, 0,   0, 1'b0, 8'hF8, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{2,    1'b1, 2,   0, 1'b0, 8'hF8, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{3,    1'b1, 3,   0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1};
    vt[3]  = '{4,    1'b1, 4,   0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{799,  1'b1, 799, 0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{800,  1'b0, 0,   0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{802,  1'b0, 0,   0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{803,  1'b0, 0,   0, 1'b0, 8'hF8, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{842,  1'b0, 0,   0, 1'b0, 8'hF8, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{843,  1'b0, 0,   0, 1'b0, 8'hF8, 1'b1, 1'b0, 1'b0};
    vt[10] = '{970,  1'b0, 0,   0, 1'b0, 8'hF8, 1'b1, 1'b0, 1'b0};
    vt[11] = '{971,  1'b0, 0,   0, 1'b0, 8'hF8, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1055, 1'b0, 0,   0, 1'b0, 8'hF8, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1056, 1'b1, 0,   1, 1'b0, 8'hF8, 1'b0, 1'b0, 1'b0};
    vt[14] = '{1058, 1'b1, 2,   1, 1'b0, 8'hF8, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1059, 1'b1, 3,   1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0};
    vt[16] = '{1060, 1'b1, 4,   1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};

    reset_a = 1'b1; enable_a = 1'b1; pattern_a = 1'b0; pd_a = 8'h5A;
    reset_b = 1'b1; enable_b = 1'b1; pattern_b = 1'b0; pd_b = 8'h00;
    repeat (3) @(negedge clk);
    chk("a_reset_hs", {31'd0, hs_a}, 32'd0);
    chk("a_reset_color", {24'd0, color_a}, 32'hF8);
    reset_a = 1'b0;
    cyc_a = 0;

    for (int i = 0; i < NV; i++) begin
      goto_a(vt[i].cyc);
      chk("a_req",   {31'd0, req_a},   {31'd0, vt[i].req});
      chk("a_x",     {22'd0, x_a},     vt[i].x);
      chk("a_y",     {22'd0, y_a},     vt[i].y);
      chk("a_de",    {31'd0, de_a},    {31'd0, vt[i].de});
      chk("a_color", {24'd0, color_a}, {24'd0, vt[i].color});
      chk("a_hs",    {31'd0, hs_a},    {31'd0, vt[i].hs});
      chk("a_vs",    {31'd0, vs_a},    32'd0);
      chk("a_ls",    {31'd0, ls_a},    {31'd0, vt[i].ls});
      chk("a_fs",    {31'd0, fs_a},    {31'd0, vt[i].fs});
    end

    // Freeze for 10 clocks at h=44 of line 1; changing pix_data must not leak through.
    goto_a(1100);
    enable_a = 1'b0;
    pd_a = 8'h11;
    chk("frz_x0", {22'd0, x_a}, 32'd44);
    goto_a(1105);
    chk("frz_x", {22'd0, x_a}, 32'd44);
    chk("frz_y", {22'd0, y_a}, 32'd1);
    chk("frz_de", {31'd0, de_a}, 32'd1);
    chk("frz_color", {24'd0, color_a}, 32'h5A);
    goto_a(1110);
    chk("frz_x_end", {22'd0, x_a}, 32'd44);
    chk("frz_color_end", {24'd0, color_a}, 32'h5A);
    enable_a = 1'b1;
    pd_a = 8'h5A;
    goto_a(1111);
    chk("run_x", {22'd0, x_a}, 32'd45);
    goto_a(1113);
    chk("run_color", {24'd0, color_a}, 32'h5A);
    goto_a(1908);
    chk("shift_hs_pre", {31'd0, hs_a}, 32'd0);
    goto_a(1909);
    chk("shift_hs", {31'd0, hs_a}, 32'd1);
    goto_a(2121);
    chk("shift_req_pre", {31'd0, req_a}, 32'd0);
    goto_a(2122);
    chk("shift_req", {31'd0, req_a}, 32'd1);
    chk("shift_y", {22'd0, y_a}, 32'd2);
    goto_a(2124);
    chk("shift_ls_pre", {31'd0, ls_a}, 32'd0);
    goto_a(2125);
    chk("shift_ls", {31'd0, ls_a}, 32'd1);

    // Asynchronous reset mid-line, then a clean restart with an empty delay line.
    goto_a(2200);
    chk("pre_rst_de", {31'd0, de_a}, 32'd1);
    reset_a = 1'b1;
    #1;
    chk("rst_de", {31'd0, de_a}, 32'd0);
    chk("rst_color", {24'd0, color_a}, 32'hF8);
    chk("rst_ls", {31'd0, ls_a}, 32'd0);
    chk("rst_req", {31'd0, req_a}, 32'd1);
    chk("rst_x", {22'd0, x_a}, 32'd0);
    repeat (2) @(negedge clk);
    reset_a = 1'b0;
    cyc_a = 0;
    goto_a(1);
    chk("rst1_de", {31'd0, de_a}, 32'd0);
    goto_a(2);
    chk("rst2_color", {24'd0, color_a}, 32'hF8);
    goto_a(3);
    chk("rst3_de", {31'd0, de_a}, 32'd1);
    chk("rst3_fs", {31'd0, fs_a}, 32'd1);

    // DUT b: two full frames plus, with the test pattern selected mid-frame 0.
    @(negedge clk);
    reset_b = 1'b0;
    pat_en = 1'b1;
    for (int c = 0; c <= 333; c++) begin
      pattern_b = pat_at(c);
      pd_b = pdv(c);
      #1;
      check_b(c);
      @(negedge clk);
    end
    reset_b = 1'b1;
    #1;
    chk("b_rst_de", {31'd0, de_b}, 32'd0);
    chk("b_rst_color", {24'd0, color_b}, 32'hF8);
    chk("b_rst_hs", {31'd0, hs_b}, 32'd1);
    chk("b_rst_req", {31'd0, req_b}, 32'd1);
    repeat (2) @(negedge clk);
    reset_b = 1'b0;
    pat_en = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      pattern_b = pat_at(c);
      pd_b = pdv(c);
      #1;
      check_b(c);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
